// File: rtl/modn_digit_counter.sv
// rtl/modn_digit_counter.sv - multi-digit modulo-N up/down counter with load and terminal count (optional MODCNT_MATCH_EN compare)
module modn_digit_counter #(
    parameter int  MODULUS = 10,
    parameter int  DIGITS  = 4,
    localparam int DW      = $clog2(MODULUS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 up_dn,
    input  logic                 load,
    input  logic [DIGITS*DW-1:0] load_val,
    output logic [DIGITS*DW-1:0] count,
    output logic                 tc,
    output logic                 load_err
`ifdef MODCNT_MATCH_EN
    ,
    input  logic [DIGITS*DW-1:0] match_val,
    output logic                 match
`endif
);

    // Largest legal digit, the constant one, and the modulus widened by a bit so
    // that a power-of-two modulus does not truncate to zero in the range check.
    localparam logic [DW-1:0] MAX_DIGIT = DW'(MODULUS - 1);
    localparam logic [DW-1:0] ONE       = DW'(1);
    localparam logic [DW:0]   MOD_W     = (DW + 1)'(MODULUS);

    logic [DIGITS*DW-1:0] count_q, count_d;
    logic                 tc_q, tc_d;
    logic                 load_err_q, load_err_d;

    // Per-digit scratch used while walking the ripple chain.
    logic [DW-1:0] dig;
    logic          at_edge;
    logic          step;

    // Next-state: load sanitises each digit; counting ripples a carry/borrow
    // from digit 0 upward, and a carry out of the top digit is the full wrap.
    always_comb begin
        count_d    = count_q;
        tc_d       = 1'b0;
        load_err_d = 1'b0;
        dig        = '0;
        at_edge    = 1'b0;
        step       = 1'b1;
        if (load) begin
            for (int k = 0; k < DIGITS; k++) begin
                dig = load_val[k*DW +: DW];
                if ({1'b0, dig} >= MOD_W) begin
                    count_d[k*DW +: DW] = '0;
                    load_err_d          = 1'b1;
                end else begin
                    count_d[k*DW +: DW] = dig;
                end
            end
        end else if (en) begin
            for (int k = 0; k < DIGITS; k++) begin
                dig = count_q[k*DW +: DW];
                if (up_dn) begin
                    at_edge = (dig == MAX_DIGIT);
                    if (step) begin
                        count_d[k*DW +: DW] = at_edge ? '0 : dig + ONE;
                    end
                end else begin
                    at_edge = (dig == '0);
                    if (step) begin
                        count_d[k*DW +: DW] = at_edge ? MAX_DIGIT : dig - ONE;
                    end
                end
                step = step & at_edge;
            end
            tc_d = step;
        end
    end

    // State registers; reset overrides load and count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q    <= '0;
            tc_q       <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            tc_q       <= tc_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign tc       = tc_q;
    assign load_err = load_err_q;

`ifdef MODCNT_MATCH_EN
    logic match_q, match_d;

    // Compare against the value the count register is about to take, so the
    // registered flag lines up with the count it describes.
    always_comb begin
        match_d = (count_d == match_val);
    end

    // Match register, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match = match_q;
`endif

endmodule

// File: tb/tb_modn_digit_counter.sv
// tb/tb_modn_digit_counter.sv - self-checking bench for modn_digit_counter (optionally with MODCNT_MATCH_EN)
module tb_modn_digit_counter;

    localparam int MOD   = 10;
    localparam int ND    = 4;
    localparam int W     = $clog2(MOD);
    localparam int PW    = ND * W;
    localparam int TOTAL = MOD ** ND;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          up_dn = 1'b0;
    logic          load = 1'b0;
    logic [PW-1:0] load_val = '0;
    logic [PW-1:0] count;
    logic          tc;
    logic          load_err;
`ifdef MODCNT_MATCH_EN
    logic [PW-1:0] match_val = '0;
    logic          match;
    bit            m_match = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // Model: the counter as a plain integer in 0..TOTAL-1.
    int m_val = 0;
    bit m_tc  = 1'b0;
    bit m_err = 1'b0;
    bit chk   = 1'b0;

    always #5 clk = ~clk;

    modn_digit_counter #(.MODULUS(MOD), .DIGITS(ND)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .load_err (load_err)
`ifdef MODCNT_MATCH_EN
        ,
        .match_val(match_val),
        .match    (match)
`endif
    );

    function automatic logic [PW-1:0] pack(int v);
        logic [PW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int k = 0; k < ND; k++) begin
            r[k*W +: W] = W'(x % MOD);
            x = x / MOD;
        end
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then advance the model on the same edge.
    task automatic step(bit r, bit ld, bit e, bit u, logic [PW-1:0] lv);
        int v;
        int p;
        int d;
        @(negedge clk);
        rst      = r;
        load     = ld;
        en       = e;
        up_dn    = u;
        load_val = lv;
        @(posedge clk);
        if (r) begin
            m_val = 0;
            m_tc  = 1'b0;
            m_err = 1'b0;
        end else if (ld) begin
            v     = 0;
            p     = 1;
            m_err = 1'b0;
            for (int k = 0; k < ND; k++) begin
                d = int'(lv[k*W +: W]);
                if (d >= MOD) begin
                    d     = 0;
                    m_err = 1'b1;
                end
                v = v + d * p;
                p = p * MOD;
            end
            m_val = v;
            m_tc  = 1'b0;
        end else if (e) begin
            m_err = 1'b0;
            if (u) begin
                m_tc  = (m_val == TOTAL - 1);
                m_val = (m_val + 1) % TOTAL;
            end else begin
                m_tc  = (m_val == 0);
                m_val = (m_val + TOTAL - 1) % TOTAL;
            end
        end else begin
            m_tc  = 1'b0;
            m_err = 1'b0;
        end
`ifdef MODCNT_MATCH_EN
        m_match = r ? 1'b0 : (pack(m_val) == match_val);
`endif
        #1;
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk) begin
            check("count", 32'(count), 32'(pack(m_val)));
            check("tc", 32'(tc), 32'(m_tc));
            check("load_err", 32'(load_err), 32'(m_err));
`ifdef MODCNT_MATCH_EN
            check("match", 32'(match), 32'(m_match));
`endif
        end
    end

    initial begin
        step(1, 0, 0, 1, '0);
        chk = 1'b1;
        check("reset_count", 32'(count), 32'h0);
        check("reset_tc", 32'(tc), 32'h0);

        // Reset mid-count at 0x1234.
        step(0, 1, 0, 1, 16'h1233);
        step(0, 0, 1, 1, '0);
        check("pre_rst_1234", 32'(count), 32'h1234);
        step(1, 0, 1, 1, '0);
        check("rst_count", 32'(count), 32'h0000);
        check("rst_tc", 32'(tc), 32'h0);
        check("rst_err", 32'(load_err), 32'h0);

        // Up wrap.
        step(0, 1, 0, 1, 16'h9998);
        step(0, 0, 1, 1, '0);
        check("up_9999", 32'(count), 32'h9999);
        check("up_9999_tc", 32'(tc), 32'h0);
        step(0, 0, 1, 1, '0);
        check("up_wrap", 32'(count), 32'h0000);
        check("up_wrap_tc", 32'(tc), 32'h1);
        step(0, 0, 1, 1, '0);
        check("up_after_tc", 32'(tc), 32'h0);

        // Down borrow and wrap.
        step(0, 1, 0, 0, 16'h1000);
        step(0, 0, 1, 0, '0);
        check("down_borrow", 32'(count), 32'h0999);
        step(0, 1, 0, 0, 16'h0000);
        step(0, 0, 1, 0, '0);
        check("down_wrap", 32'(count), 32'h9999);
        check("down_wrap_tc", 32'(tc), 32'h1);

        // Load sanitise and load-over-enable priority.
        step(0, 1, 1, 1, 16'h3C5F);
        check("sanitise", 32'(count), 32'h3050);
        check("sanitise_err", 32'(load_err), 32'h1);
        check("sanitise_tc", 32'(tc), 32'h0);
        step(0, 0, 0, 1, '0);
        check("err_clear", 32'(load_err), 32'h0);

        // Hold, then direction changes.
        step(0, 1, 0, 1, 16'h0042);
        for (int i = 0; i < 5; i++) step(0, 0, 0, i[0], 16'hFFFF);
        check("hold", 32'(count), 32'h0042);
        step(0, 0, 1, 1, '0);
        check("dir_up1", 32'(count), 32'h0043);
        step(0, 0, 1, 1, '0);
        check("dir_up2", 32'(count), 32'h0044);
        step(0, 0, 1, 0, '0);
        check("dir_down", 32'(count), 32'h0043);

        // Reset wins over load.
        step(1, 1, 1, 1, 16'h5555);
        check("rst_over_load", 32'(count), 32'h0000);

        // Long sweeps with occasional direction flips and idle cycles.
        step(0, 1, 0, 1, 16'h0990);
        for (int i = 0; i < 1200; i++) step(0, 0, (i % 11) != 5, (i % 7) != 0, '0);
        step(0, 1, 0, 0, 16'h0015);
        for (int i = 0; i < 1200; i++) step(0, 0, 1, (i % 9) == 0, '0);

`ifdef MODCNT_MATCH_EN
        match_val = 16'h0005;
        step(1, 0, 0, 1, '0);
        check("match_rst", 32'(match), 32'h0);
        for (int i = 1; i <= 8; i++) begin
            step(0, 0, 1, 1, '0);
            check("match_up", 32'(match), (i == 5) ? 32'h1 : 32'h0);
        end
`endif

        chk = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
